pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_if.sv | 46 ++++
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Bundles the ID-stage decode bits, the EX branch resolution and the
//   hazard-controller outputs into one port.
//   master : pipeline side. Drives the id_* fields and ex_br_taken, and
//            receives the enables, flush/bubble, forwarding selects and counters.
//   slave  : pipe_hazard_ctrl side.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic             id_rn_used;
    logic             id_rm_used;
    logic [REG_W-1:0] id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             id_set_flags;
    logic             id_uses_flags;
    logic             ex_br_taken;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             fwd_flags;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rn, id_rm, id_rn_used, id_rm_used, id_rd,
               id_regwrite, id_memread, id_set_flags, id_uses_flags, ex_br_taken,
        input  pc_write, ifid_write, ifid_flush, idex_bubble,
               fwd_a, fwd_b, fwd_flags, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_rn_used, id_rm_used, id_rd,
               id_regwrite, id_memread, id_set_flags, id_uses_flags, ex_br_taken,
        output pc_write, ifid_write, ifid_flush, idex_bubble,
               fwd_a, fwd_b, fwd_flags, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and sequencing controller for the 5-stage CPU, placed beside ID.
//   Keeps a shadow copy of the in-flight instructions and derives the stall,
//   the flush, the forwarding selects and two saturating event counters.
//   Ports:
//     clk - pipeline clock (rising edge)
//     rst - asynchronous active-high reset
//     hz  - pipe_hazard_ctrl_if.slave (ID decode, branch resolution, outputs)
//   Build option: define FORWARD_EN to enable operand/flag forwarding. Without
//   it, every EX/MEM dependency stalls and all forwarding selects are 0.
module pipe_hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
    } entry_t;

    // The WB producer writes the register file on the falling edge, so ID
    // already reads its value. Its entry is therefore not kept.
    entry_t           ex_q, ex_d, mem_q, mem_d;
    logic             ex_memread_q, ex_memread_d;
    logic             ex_set_flags_q, ex_set_flags_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       ex_rn, ex_rm, mem_rn, mem_rm;
    logic       stall, flush, stall_eff;
    logic [1:0] fwd_a, fwd_b;
    logic       fwd_flags;

    function automatic logic match(input entry_t e, input logic [REG_W-1:0] r,
                                   input logic used);
        return used & e.valid & e.regwrite & (e.rd == r) & (r != ZR);
    endfunction

    always_comb begin
        ex_rn  = match(ex_q,  hz.id_rn, hz.id_rn_used);
        ex_rm  = match(ex_q,  hz.id_rm, hz.id_rm_used);
        mem_rn = match(mem_q, hz.id_rn, hz.id_rn_used);
        mem_rm = match(mem_q, hz.id_rm, hz.id_rm_used);

`ifdef FORWARD_EN
        stall     = hz.id_valid & ex_memread_q & (ex_rn | ex_rm);
        // The selects are consumed one cycle later, when the producer now in
        // EX sits in EX/MEM and the one now in MEM sits in MEM/WB.
        fwd_a     = ~hz.id_valid ? 2'b00 : ex_rn ? 2'b10 : mem_rn ? 2'b01 : 2'b00;
        fwd_b     = ~hz.id_valid ? 2'b00 : ex_rm ? 2'b10 : mem_rm ? 2'b01 : 2'b00;
        fwd_flags = hz.id_uses_flags & ex_q.valid & ex_set_flags_q;
`else
        stall     = hz.id_valid & ((ex_memread_q & (ex_rn | ex_rm)) |
                                   ex_rn | ex_rm | mem_rn | mem_rm |
                                   (hz.id_uses_flags & ex_q.valid & ex_set_flags_q));
        fwd_a     = 2'b00;
        fwd_b     = 2'b00;
        fwd_flags = 1'b0;
`endif

        // A taken branch squashes the instruction in ID, so it overrides the stall.
        flush     = hz.ex_br_taken & ~rst;
        stall_eff = stall & ~hz.ex_br_taken;

        ex_d           = '0;
        ex_memread_d   = 1'b0;
        ex_set_flags_d = 1'b0;
        if (hz.id_valid & ~stall & ~hz.ex_br_taken) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = hz.id_rd;
            ex_d.regwrite  = hz.id_regwrite;
            ex_memread_d   = hz.id_memread;
            ex_set_flags_d = hz.id_set_flags;
        end
        mem_d = ex_q;

        stall_cnt_d = stall_cnt_q;
        if (stall_eff && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        flush_cnt_d = flush_cnt_q;
        if (hz.ex_br_taken && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q           <= '0;
            mem_q          <= '0;
            ex_memread_q   <= 1'b0;
            ex_set_flags_q <= 1'b0;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
        end else begin
            ex_q           <= ex_d;
            mem_q          <= mem_d;
            ex_memread_q   <= ex_memread_d;
            ex_set_flags_q <= ex_set_flags_d;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    assign hz.pc_write    = ~stall_eff;
    assign hz.ifid_write  = ~stall_eff;
    assign hz.ifid_flush  = flush;
    assign hz.idex_bubble = flush | stall_eff;
    assign hz.fwd_a       = fwd_a;
    assign hz.fwd_b       = fwd_b;
    assign hz.fwd_flags   = fwd_flags;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl. The reference model records
//   which instruction entered EX in each cycle and derives the hazards from
//   the age of each producer. A second instance with 2-bit counters exercises
//   saturation. Build with or without FORWARD_EN.
module tb_pipe_hazard_ctrl;
    typedef struct packed {
        logic       v;
        logic [4:0] rd, rn, rm;
        logic       rnu, rmu, rw, mr, sf, uf;
    } ins_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) hz ();
    pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(2))  hz2 ();

    pipe_hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hz(hz.slave));
    pipe_hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .hz(hz2.slave));

    assign hz2.id_valid      = hz.id_valid;
    assign hz2.id_rn         = hz.id_rn;
    assign hz2.id_rm         = hz.id_rm;
    assign hz2.id_rn_used    = hz.id_rn_used;
    assign hz2.id_rm_used    = hz.id_rm_used;
    assign hz2.id_rd         = hz.id_rd;
    assign hz2.id_regwrite   = hz.id_regwrite;
    assign hz2.id_memread    = hz.id_memread;
    assign hz2.id_set_flags  = hz.id_set_flags;
    assign hz2.id_uses_flags = hz.id_uses_flags;
    assign hz2.ex_br_taken   = hz.ex_br_taken;

`ifdef FORWARD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    // Model state: instruction that entered EX in cycle c lives in hist[c%4].
    ins_t        hist [4];
    int unsigned cyc = 0;
    int          m_stall = 0;
    int          m_flush = 0;
    ins_t        cur;
    logic        cur_br;
    logic [8:0]  exp_ctl;
    logic        exp_st;
    logic [15:0] exp_sc, exp_fc;
    localparam ins_t NOP = '0;

    function automatic ins_t mk(input logic [4:0] rd, input logic [4:0] rn,
                                input logic [4:0] rm, input logic rnu, input logic rmu,
                                input logic rw, input logic mr, input logic sf,
                                input logic uf);
        ins_t t;
        t = '{v: 1'b1, rd: rd, rn: rn, rm: rm, rnu: rnu, rmu: rmu,
              rw: rw, mr: mr, sf: sf, uf: uf};
        return t;
    endfunction

    function automatic logic dep(input ins_t p, input logic [4:0] r, input logic used);
        return used && p.v && p.rw && (p.rd == r) && (r != 5'd31);
    endfunction

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    function automatic logic [8:0] obs_ctl();
        return {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble,
                hz.fwd_a, hz.fwd_b, hz.fwd_flags};
    endfunction

    function automatic logic [8:0] obs_ctl2();
        return {hz2.pc_write, hz2.ifid_write, hz2.ifid_flush, hz2.idex_bubble,
                hz2.fwd_a, hz2.fwd_b, hz2.fwd_flags};
    endfunction

    task automatic reset_model();
        for (int unsigned i = 0; i < 4; i++) hist[i] = NOP;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Drive the ID instruction and branch flag; compute the expected outputs.
    task automatic apply(input ins_t i, input logic br);
        ins_t d1, d2;
        logic a1, b1, a2, b2, flg, st;
        logic [1:0] fa, fb;
        logic ff;
        cur = i;
        cur_br = br;
        hz.id_valid = i.v;     hz.id_rn = i.rn;          hz.id_rm = i.rm;
        hz.id_rn_used = i.rnu; hz.id_rm_used = i.rmu;    hz.id_rd = i.rd;
        hz.id_regwrite = i.rw; hz.id_memread = i.mr;     hz.id_set_flags = i.sf;
        hz.id_uses_flags = i.uf;
        hz.ex_br_taken = br;
        d1 = hist[(cyc + 3) % 4];   // issued one cycle ago
        d2 = hist[(cyc + 2) % 4];   // issued two cycles ago
        a1 = dep(d1, i.rn, i.rnu);  b1 = dep(d1, i.rm, i.rmu);
        a2 = dep(d2, i.rn, i.rnu);  b2 = dep(d2, i.rm, i.rmu);
        flg = i.uf && d1.v && d1.sf;
        if (FWD == 1) begin
            st = i.v && d1.mr && (a1 || b1);
            fa = !i.v ? 2'b00 : a1 ? 2'b10 : a2 ? 2'b01 : 2'b00;
            fb = !i.v ? 2'b00 : b1 ? 2'b10 : b2 ? 2'b01 : 2'b00;
            ff = flg;
        end else begin
            st = i.v && (a1 || b1 || a2 || b2 || flg);
            fa = 2'b00;
            fb = 2'b00;
            ff = 1'b0;
        end
        exp_st  = st && !br;
        exp_ctl = {br ? 4'b1111 : st ? 4'b0001 : 4'b1100, fa, fb, ff};
        exp_sc  = 16'(m_stall);
        exp_fc  = 16'(m_flush);
    endtask

    task automatic step();
        @(posedge clk);
        hist[cyc % 4] = (cur.v && !exp_st && !cur_br) ? cur : NOP;
        cyc++;
        if (exp_st && m_stall < 65535) m_stall++;
        if (cur_br && m_flush < 65535) m_flush++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            apply(NOP, 1'b0);
            step();
        end
    endtask

    // Holds a consumer in ID until it issues, checking every cycle.
    task automatic consume(input string name, input ins_t c, output int nst,
                           output logic [8:0] last);
        bit done = 1'b0;
        nst = 0;
        last = '0;
        for (int k = 0; k < 6 && !done; k++) begin
            apply(c, 1'b0);
            @(negedge clk);
            n_cmp++;
            if (obs_ctl() !== exp_ctl) begin
                n_bad++;
                $display("FAIL %s ctl cycle %0d: got %b want %b", name, k, obs_ctl(), exp_ctl);
            end
            n_cmp++;
            if (hz.stall_cnt !== exp_sc || hz.flush_cnt !== exp_fc) begin
                n_bad++;
                $display("FAIL %s counters: got %0d/%0d want %0d/%0d", name,
                         hz.stall_cnt, hz.flush_cnt, exp_sc, exp_fc);
            end
            if (hz.pc_write === 1'b0) nst++;
            last = obs_ctl();
            done = !exp_st;
            step();
        end
    endtask

    task automatic test_reset();
        ins_t ld, use_i;
        ld    = mk(5'd1, 5'd2, 5'd0, 1, 0, 1, 1, 0, 0);
        use_i = mk(5'd2, 5'd1, 5'd3, 1, 1, 1, 0, 1, 0);
        @(negedge clk);
        n_cmp++;
        if (obs_ctl() !== 9'b1100_0000_0 || hz.stall_cnt !== 16'd0 || hz.flush_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %b %0d %0d want 110000000 0 0",
                     obs_ctl(), hz.stall_cnt, hz.flush_cnt);
        end
        step();
        apply(NOP, 1'b1);
        step();
        apply(ld, 1'b0);
        step();
        apply(use_i, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (obs_ctl() !== exp_ctl || hz.flush_cnt !== exp_fc) begin
            n_bad++;
            $display("FAIL reset_prestall: got %b fc %0d want %b fc %0d",
                     obs_ctl(), hz.flush_cnt, exp_ctl, exp_fc);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs_ctl() !== 9'b1100_0000_0 || hz.stall_cnt !== 16'd0 || hz.flush_cnt !== 16'd0 ||
            hz2.stall_cnt !== 2'd0 || hz2.flush_cnt !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_midstall: got %b %0d %0d want 110000000 0 0",
                     obs_ctl(), hz.stall_cnt, hz.flush_cnt);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        reset_model();
        apply(use_i, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (obs_ctl() !== exp_ctl || hz.stall_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_nostale: got %b sc %0d want %b sc 0",
                     obs_ctl(), hz.stall_cnt, exp_ctl);
        end
        step();
    endtask

    task automatic test_load_use();
        int nst, s0;
        logic [8:0] last;
        idle(3);
        s0 = m_stall;
        apply(mk(5'd1, 5'd2, 5'd0, 1, 0, 1, 1, 0, 0), 1'b0);   // LDUR X1,[X2]
        step();
        consume("load_use", mk(5'd2, 5'd1, 5'd3, 1, 1, 1, 0, 1, 0), nst, last); // ADDS X2,X1,X3
        n_cmp++;
        if (nst != 2 - FWD) begin
            n_bad++;
            $display("FAIL load_use_len: got %0d want %0d", nst, 2 - FWD);
        end
        n_cmp++;
        if (hz.stall_cnt !== 16'(s0 + 2 - FWD)) begin
            n_bad++;
            $display("FAIL load_use_cnt: got %0d want %0d", hz.stall_cnt, s0 + 2 - FWD);
        end
        n_cmp++;
        if (last[4:3] !== ((FWD == 1) ? 2'b01 : 2'b00)) begin
            n_bad++;
            $display("FAIL load_use_fwd: got %b want %b", last[4:3], (FWD == 1) ? 2'b01 : 2'b00);
        end
    endtask

    task automatic test_alu_forward();
        int nst;
        logic [8:0] last;
        idle(3);
        apply(mk(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 1, 0), 1'b0);    // ADDS X1,X2,X3
        step();
        consume("alu_fwd", mk(5'd4, 5'd1, 5'd1, 1, 1, 1, 0, 1, 0), nst, last); // SUBS X4,X1,X1
        n_cmp++;
        if (nst != 2 - 2 * FWD || last[4:1] !== ((FWD == 1) ? 4'b1010 : 4'b0000)) begin
            n_bad++;
            $display("FAIL alu_fwd: got stalls %0d fwd %b want %0d %b", nst, last[4:1],
                     2 - 2 * FWD, (FWD == 1) ? 4'b1010 : 4'b0000);
        end
        idle(3);
        apply(mk(5'd31, 5'd2, 5'd3, 1, 1, 1, 0, 1, 0), 1'b0);   // ADDS XZR,X2,X3
        step();
        consume("xzr", mk(5'd4, 5'd31, 5'd31, 1, 1, 1, 0, 1, 0), nst, last);
        n_cmp++;
        if (nst != 0 || last[4:0] !== 5'b0) begin
            n_bad++;
            $display("FAIL xzr: got stalls %0d fwd %b want 0 00000", nst, last[4:0]);
        end
        idle(3);
        apply(mk(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 1, 0), 1'b0);    // ADDS X1,X2,X3
        step();
        consume("bcond", mk(5'd0, 5'd1, 5'd0, 1, 0, 0, 0, 0, 1), nst, last);   // B.cond on X1, flags
        n_cmp++;
        if (nst != 2 - 2 * FWD || last[4:0] !== ((FWD == 1) ? 5'b10001 : 5'b00000)) begin
            n_bad++;
            $display("FAIL bcond: got stalls %0d fwd %b want %0d %b", nst, last[4:0],
                     2 - 2 * FWD, (FWD == 1) ? 5'b10001 : 5'b00000);
        end
    endtask

    task automatic test_priority();
        int nst;
        logic [8:0] last;
        idle(3);
        apply(mk(5'd5, 5'd6, 5'd7, 1, 1, 1, 0, 0, 0), 1'b0);    // ADD X5,X6,X7
        step();
        apply(mk(5'd5, 5'd6, 5'd7, 1, 1, 1, 0, 0, 0), 1'b0);    // ADD X5,X6,X7
        step();
        consume("priority", mk(5'd8, 5'd5, 5'd9, 1, 1, 1, 0, 0, 0), nst, last);
        n_cmp++;
        if (nst != 2 - 2 * FWD || last[4:1] !== ((FWD == 1) ? 4'b1000 : 4'b0000)) begin
            n_bad++;
            $display("FAIL priority: got stalls %0d fwd %b want %0d %b", nst, last[4:1],
                     2 - 2 * FWD, (FWD == 1) ? 4'b1000 : 4'b0000);
        end
    endtask

    task automatic test_flush_vs_stall();
        int s0, f0;
        idle(3);
        apply(mk(5'd1, 5'd2, 5'd0, 1, 0, 1, 1, 0, 0), 1'b0);    // LDUR X1
        step();
        apply(mk(5'd2, 5'd1, 5'd3, 1, 1, 1, 0, 0, 0), 1'b1);    // dependent + taken branch
        s0 = m_stall;
        f0 = m_flush;
        @(negedge clk);
        n_cmp++;
        if (obs_ctl() !== exp_ctl || obs_ctl() !== {4'b1111, obs_ctl()[4:0]}) begin
            n_bad++;
            $display("FAIL flush_vs_stall ctl: got %b want %b", obs_ctl(), exp_ctl);
        end
        step();
        n_cmp++;
        if (hz.stall_cnt !== 16'(s0) || hz.flush_cnt !== 16'(f0 + 1)) begin
            n_bad++;
            $display("FAIL flush_vs_stall cnt: got %0d/%0d want %0d/%0d",
                     hz.stall_cnt, hz.flush_cnt, s0, f0 + 1);
        end
    endtask

    task automatic test_back_to_back();
        int f0;
        idle(2);
        apply(mk(5'd1, 5'd2, 5'd0, 1, 0, 1, 1, 1, 0), 1'b0);
        step();
        f0 = m_flush;
        for (int k = 0; k < 4; k++) begin
            apply(mk(5'd3, 5'd1, 5'd1, 1, 1, 1, 0, 0, 1), 1'b1);
            @(negedge clk);
            n_cmp++;
            if (obs_ctl() !== exp_ctl || obs_ctl() !== {4'b1111, obs_ctl()[4:0]}) begin
                n_bad++;
                $display("FAIL back_to_back %0d: got %b want %b", k, obs_ctl(), exp_ctl);
            end
            step();
        end
        n_cmp++;
        if (hz.flush_cnt !== 16'(f0 + 4)) begin
            n_bad++;
            $display("FAIL back_to_back cnt: got %0d want %0d", hz.flush_cnt, f0 + 4);
        end
    endtask

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        ins_t c;
        logic br;
        c = NOP;
        for (int k = 0; k < 400; k++) begin
            if (!exp_st) begin
                c = mk(rreg(), rreg(), rreg(), 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom), 1'($urandom));
                c.v = ($urandom_range(0, 9) != 0);
            end
            br = ($urandom_range(0, 7) == 0);
            apply(c, br);
            @(negedge clk);
            n_cmp++;
            if (obs_ctl() !== exp_ctl || obs_ctl2() !== exp_ctl) begin
                n_bad++;
                $display("FAIL random %0d ctl: got %b/%b want %b", k, obs_ctl(), obs_ctl2(), exp_ctl);
            end
            n_cmp++;
            if (hz.stall_cnt !== exp_sc || hz.flush_cnt !== exp_fc ||
                hz2.stall_cnt !== 2'(sat3(m_stall)) || hz2.flush_cnt !== 2'(sat3(m_flush))) begin
                n_bad++;
                $display("FAIL random %0d cnt: got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d", k,
                         hz.stall_cnt, hz.flush_cnt, hz2.stall_cnt, hz2.flush_cnt,
                         exp_sc, exp_fc, sat3(m_stall), sat3(m_flush));
            end
            step();
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 20 && (m_stall < 4 || m_flush < 4); k++) begin
            apply(mk(5'd1, 5'd2, 5'd0, 1, 0, 1, 1, 0, 0), 1'b0);
            step();
            apply(mk(5'd2, 5'd1, 5'd1, 1, 1, 1, 0, 0, 0), 1'b0);
            step();
            apply(NOP, 1'b1);
            step();
        end
        n_cmp++;
        if (hz2.stall_cnt !== 2'd3 || hz2.flush_cnt !== 2'd3) begin
            n_bad++;
            $display("FAIL saturation: got %0d/%0d want 3/3", hz2.stall_cnt, hz2.flush_cnt);
        end
        n_cmp++;
        if (hz.stall_cnt !== 16'(m_stall) || hz.flush_cnt !== 16'(m_flush)) begin
            n_bad++;
            $display("FAIL saturation wide: got %0d/%0d want %0d/%0d",
                     hz.stall_cnt, hz.flush_cnt, m_stall, m_flush);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_model();
        apply(NOP, 1'b0);
        #12 rst = 1'b0;
        test_reset();
        test_load_use();
        test_alu_forward();
        test_priority();
        test_flush_vs_stall();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
